// File: rtl/hamming_dec_arbiter.sv
// ============================================================================
// Module      : hamming_dec_arbiter
// Description : Round-robin sharing of one Hamming(7,4) decoder between two
//               receive channels, with a one-deep output register and
//               per-channel saturating error counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_dec_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr_cnt,
    input  logic             ch0_valid,
    input  logic [6:0]       ch0_data,
    output logic             ch0_ready,
    input  logic             ch1_valid,
    input  logic [6:0]       ch1_data,
    output logic             ch1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic             out_ch,
    output logic [CNT_W-1:0] err_cnt0,
    output logic [CNT_W-1:0] err_cnt1
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;
    logic [3:0]       r_data;
    logic             r_err;
    logic             r_ch;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_space;
    logic             w_gnt_en;
    logic             w_gnt_ch;
    logic             w_accept;
    logic [6:0]       w_cw;
    logic [2:0]       w_syn;
    logic [6:0]       w_fixed;
    logic [3:0]       w_data;
    logic             w_err;

    // Arbitration: a lone requester always wins; contention goes to the
    // channel that was not granted last.
    always_comb begin
        w_space  = (r_state == S_EMPTY) | out_ready;
        w_gnt_en = ~rst & en & w_space;
        if (ch0_valid & ch1_valid) begin
            w_gnt_ch = ~r_last_grant;
        end else begin
            w_gnt_ch = ch1_valid;
        end
        ch0_ready = w_gnt_en & ~w_gnt_ch;
        ch1_ready = w_gnt_en & w_gnt_ch;
        w_accept  = (ch0_ready & ch0_valid) | (ch1_ready & ch1_valid);
    end

    // Syndrome value equals the 1-based position of a single flipped bit.
    always_comb begin
        w_cw     = w_gnt_ch ? ch1_data : ch0_data;
        w_syn[0] = w_cw[0] ^ w_cw[2] ^ w_cw[4] ^ w_cw[6];
        w_syn[1] = w_cw[1] ^ w_cw[2] ^ w_cw[5] ^ w_cw[6];
        w_syn[2] = w_cw[3] ^ w_cw[4] ^ w_cw[5] ^ w_cw[6];
        for (int i = 0; i < 7; i++) begin
            w_fixed[i] = w_cw[i] ^ (w_syn == 3'(i + 1));
        end
        w_data = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
        w_err  = |w_syn;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (out_ready & ~w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_last_grant <= 1'b1;
            r_data       <= 4'd0;
            r_err        <= 1'b0;
            r_ch         <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data       <= w_data;
                r_err        <= w_err;
                r_ch         <= w_gnt_ch;
                r_last_grant <= w_gnt_ch;
            end
            if (clr_cnt) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (w_accept & w_err) begin
                if (~w_gnt_ch && r_cnt0 != C_CNT_MAX) r_cnt0 <= r_cnt0 + 1'b1;
                if (w_gnt_ch && r_cnt1 != C_CNT_MAX)  r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign out_err   = r_err;
    assign out_ch    = r_ch;
    assign err_cnt0  = r_cnt0;
    assign err_cnt1  = r_cnt1;

endmodule

`default_nettype wire

// File: tb/tb_hamming_dec_arbiter.sv
// ============================================================================
// Module      : tb_hamming_dec_arbiter
// Description : Self-checking bench: decode vectors, directed corner cases
//               and random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hamming_dec_arbiter;

    logic       clk = 1'b0;
    logic       rst, en, clr_cnt, out_ready;
    logic       ch0_valid, ch1_valid;
    logic [6:0] ch0_data, ch1_data;

    logic       ch0_ready, ch1_ready, out_valid, out_err, out_ch;
    logic [3:0] out_data;
    logic [7:0] err_cnt0, err_cnt1;

    logic       s_ch0_ready, s_ch1_ready, s_out_valid, s_out_err, s_out_ch;
    logic [3:0] s_out_data;
    logic [1:0] s_err_cnt0, s_err_cnt1;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    hamming_dec_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(ch1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_ch(out_ch),
        .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
    );

    hamming_dec_arbiter #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
        .ch0_valid(ch0_valid), .ch0_data(ch0_data), .ch0_ready(s_ch0_ready),
        .ch1_valid(ch1_valid), .ch1_data(ch1_data), .ch1_ready(s_ch1_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_err(s_out_err), .out_ch(s_out_ch),
        .err_cnt0(s_err_cnt0), .err_cnt1(s_err_cnt1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    // Reference decoder: nearest valid codeword by exhaustive search.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [4:0] dec(input logic [6:0] cw);
        logic [4:0] r;
        r = 5'd0;
        for (int v = 0; v < 16; v++) begin
            if ($countones(enc(4'(v)) ^ cw) <= 1)
                r = {4'(v), ($countones(enc(4'(v)) ^ cw) == 1)};
        end
        return r;
    endfunction

    logic       m_full, m_err, m_ch, m_last;
    logic [3:0] m_data;
    int         m_cnt[2];
    int         m_scnt[2];

    function automatic logic m_gok();
        return !rst && en && (!m_full || out_ready);
    endfunction

    function automatic logic m_gch();
        if (ch0_valid && ch1_valid) return !m_last;
        return ch1_valid;
    endfunction

    always @(posedge clk) begin
        logic       acc, g;
        logic [4:0] r;
        if (rst) begin
            m_full = 0; m_err = 0; m_ch = 0; m_last = 1; m_data = 0;
            m_cnt[0] = 0; m_cnt[1] = 0; m_scnt[0] = 0; m_scnt[1] = 0;
        end else begin
            g   = m_gch();
            acc = m_gok() && (g ? ch1_valid : ch0_valid);
            r   = dec(g ? ch1_data : ch0_data);
            if (acc) begin
                m_full = 1; m_data = r[4:1]; m_err = r[0]; m_ch = g; m_last = g;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
            if (clr_cnt) begin
                m_cnt[0] = 0; m_cnt[1] = 0; m_scnt[0] = 0; m_scnt[1] = 0;
            end else if (acc && r[0]) begin
                if (m_cnt[g] < 255) m_cnt[g]++;
                if (m_scnt[g] < 3)  m_scnt[g]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            if (ch0_valid) chk("ch0_ready", ch0_ready, m_gok() && !m_gch());
            if (ch1_valid) chk("ch1_ready", ch1_ready, m_gok() && m_gch());
            chk("out_valid", out_valid, m_full);
            chk("s_out_valid", s_out_valid, m_full);
            if (m_full) begin
                chk("out_data", out_data, m_data);
                chk("out_err", out_err, m_err);
                chk("out_ch", out_ch, m_ch);
            end
            chk("err_cnt0", err_cnt0, m_cnt[0]);
            chk("err_cnt1", err_cnt1, m_cnt[1]);
            chk("s_err_cnt0", s_err_cnt0, m_scnt[0]);
            chk("s_err_cnt1", s_err_cnt1, m_scnt[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       ch;
        logic [6:0] cw;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vt[7];
    logic [3:0] held_data;
    logic       held_ch;

    initial begin
        vt[0] = '{1'b0, 7'b0011001, 4'h2, 1'b0};
        vt[1] = '{1'b1, 7'b0011000, 4'h2, 1'b1};
        vt[2] = '{1'b0, 7'b1111111, 4'hF, 1'b0};
        vt[3] = '{1'b1, 7'b0111111, 4'hF, 1'b1};
        vt[4] = '{1'b0, 7'b0101001, 4'h5, 1'b1};
        vt[5] = '{1'b1, 7'b0001000, 4'h0, 1'b1};
        vt[6] = '{1'b0, 7'b1001011, 4'h8, 1'b0};

        rst = 1; en = 1; clr_cnt = 0; out_ready = 1;
        ch0_valid = 0; ch1_valid = 0; ch0_data = 0; ch1_data = 0;
        tick();
        chk_on = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_cnt0", err_cnt0, 0);
        chk("rst_cnt1", err_cnt1, 0);
        tick();

        // Single-word decode vectors
        foreach (vt[i]) begin
            ch0_valid = !vt[i].ch; ch1_valid = vt[i].ch;
            ch0_data  = vt[i].cw;  ch1_data  = vt[i].cw;
            tick();
            ch0_valid = 0; ch1_valid = 0;
            @(negedge clk);
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vt[i].exp_data);
            chk("vec_err", out_err, vt[i].exp_err);
            chk("vec_ch", out_ch, vt[i].ch);
            tick();
        end

        // Contention after reset alternates starting with ch0
        rst = 1; tick(); rst = 0;
        ch0_valid = 1; ch1_valid = 1; out_ready = 1;
        for (int k = 0; k < 6; k++) begin
            ch0_data = 7'($urandom); ch1_data = 7'($urandom);
            tick();
            @(negedge clk);
            chk("alt_valid", out_valid, 1);
            chk("alt_ch", out_ch, k % 2);
        end
        ch0_valid = 0; ch1_valid = 0;
        tick();

        // Saturation on the narrow instance, then clear beats increment
        rst = 1; tick(); rst = 0;
        ch0_valid = 1; ch0_data = 7'b0011000;
        repeat (5) tick();
        @(negedge clk);
        chk("sat_s_cnt0", s_err_cnt0, 3);
        chk("sat_cnt0", err_cnt0, 5);
        tick();
        clr_cnt = 1;
        tick();
        clr_cnt = 0; ch0_valid = 0;
        @(negedge clk);
        chk("clr_s_cnt0", s_err_cnt0, 0);
        chk("clr_cnt0", err_cnt0, 0);
        tick();

        // Backpressure: held word stays put, release accepts same cycle
        ch0_valid = 1; ch1_valid = 1;
        ch0_data = 7'b0011000; ch1_data = 7'b0111111;
        out_ready = 1;
        tick();
        held_data = m_data; held_ch = m_ch;
        out_ready = 0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_ready0", ch0_ready, 0);
            chk("bp_ready1", ch1_ready, 0);
            chk("bp_hold_data", out_data, held_data);
            chk("bp_hold_ch", out_ch, held_ch);
            tick();
        end
        out_ready = 1;
        @(negedge clk);
        chk("bp_release", held_ch ? ch0_ready : ch1_ready, 1);
        tick();

        // Reset while full drops the word and clears counters
        out_ready = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt0", err_cnt0, 0);
        chk("mid_rst_cnt1", err_cnt1, 0);
        chk("mid_rst_gnt0", ch0_ready, 1);
        chk("mid_rst_gnt1", ch1_ready, 0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            en        = ($urandom_range(0, 7) != 0);
            clr_cnt   = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ch0_valid = 1'($urandom);
            ch1_valid = 1'($urandom);
            ch0_data  = 7'($urandom);
            ch1_data  = 7'($urandom);
            tick();
        end
        rst = 0; ch0_valid = 0; ch1_valid = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
